serv_csr_irq: RTL
=================

// Module: serv_csr_irq
// PURPOSE
//  Bit-serial machine-mode CSR unit for the SERV core, with multi-source interrupts. Handles
//  software, timer and external interrupts plus NUM_LOCAL platform lines, with a
//  prioritised 5-bit mcause code and readable/writable mstatus.MPIE.
//  Sits between decode/state and the CSR read/write datapath. Data moves 1 bit/clk, LSB first.
// PARAMETERS
//  NUM_LOCAL  4  local interrupt lines, 1..16; line k maps to mie/mip bit 16+k
//  SYNC       1  1: 2-flop synchroniser on every irq input; 0: inputs used directly
// PORTS
//  i_clk         in   1   clock, all state on rising edge
//  i_rst_n       in   1   asynchronous active-low reset
//  i_init,i_en   in   1   state: init phase / serial bit valid
//  i_cnt         in   5   current bit index 0..31
//  i_cnt_done    in   1   last bit of the current instruction
//  i_trap,i_mret in   1   trap entry / mret instruction
//  i_e_op,i_ebreak,i_mem_op,i_mem_cmd in 1  exception class (mem_cmd 1=store)
//  i_mstatus_en,i_mie_en,i_mip_en,i_mcause_en in 1  CSR being accessed (one-hot or none)
//  i_csr_source  in   2   00 CSR, 01 EXT(write), 10 SET, 11 CLR
//  i_csr_d_sel   in   1   1: d=i_csr_imm, 0: d=i_rs1
//  i_csr_imm,i_rs1,i_rf_csr_out in 1  serial operands; rf_csr_out = RF-held CSR bit
//  i_msip,i_mtip,i_meip in 1  standard interrupt levels
//  i_lirq        in   NUM_LOCAL  local interrupt levels
//  o_csr_in      out  1   serial value written back to the CSR
//  o_q           out  1   serial CSR read value (csr_out)
//  o_new_irq     out  1   interrupt taken for the next trap, registered
//  o_irq_pending out  1   registered: any enabled pending irq, ignoring mstatus.MIE
// BEHAVIOUR
//  Reset: MIE=MPIE=0, all mie bits 0, mcause=0, o_new_irq=0, irq_taken_r=0, sync flops 0.
//  csr_out = i_rf_csr_out | local bit. Local bits: mstatus 3=MIE, 7=MPIE.
//    mie/mip bits 3,7,11,16+k. mcause 0..4=code, 31=int flag.
//    Local bit is 0 when no matching en, when !i_en, or at any other index.
//  csr_in: EXT d; SET csr_out|d; CLR csr_out&~d; CSR csr_out.
//  Writes: i_en & en & i_cnt==bit index loads csr_in. mip is read-only; writes are dropped.
//  mcause code: 5-bit shift reg. When i_mcause_en&i_en&i_cnt<5, it shifts right,
//    with csr_in entering bit 4 and bit 0 driving the read, so it is restored after 5 clks.
//    Bit 31 loads csr_in at i_cnt_done.
//  Pending: p = mip & mie. o_irq_pending <= |p each clk.
//    take = MIE & |p, evaluated at i_cnt_done & !i_init.
//  Priority, highest first: lirq[NUM_LOCAL-1]..lirq[0], MEI(11), MSI(3), MTI(7).
//    The winner's code (16+k/11/3/7) is latched into irq_id at the same edge.
//  o_new_irq <= take & !irq_taken_r, and irq_taken_r <= take, both at that edge.
//    o_new_irq therefore holds for exactly one instruction, and a level held high raises one trap.
//  Trap at i_cnt_done: MPIE<=MIE, MIE<=0, mcause31<=o_new_irq.
//    code <= irq_id if o_new_irq, else ebreak 3, ecall 11, load 4, store 6, jump 0.
//  mret: MIE<=MPIE, MPIE<=1. Wins over mstatus CSR writes; trap wins over mret.
//  Simultaneous pending sources: only the highest-priority one is reported.
//    Lower ones remain in mip and fire after the re-arm (take drops then rises).
//  Reset asserted mid-instruction: all state clears immediately. No partial shift persists.
// STRUCTURE
//  serv_csr_pkg: CSR_SOURCE_* encodings, bit indices (MIE=3, MPIE=7, MSI=3, MTI=7, MEI=11,
//    LOCAL_BASE=16), exception codes.
//  Sub-module serv_irq_prio: synchronisers, pending/enable AND, priority encoder -> 5-bit irq_id.
//  Top level holds CSR registers, serial mux and trap/mret sequencing.
// TESTING
//  1. Reset; read mstatus, mie, mcause serially -> all 32 bits 0. o_new_irq=0.
//  2. CSRRW mie=0x0001_0880, MIE=1, i_mtip=1 -> o_new_irq=1 after next cnt_done.
//     Trap -> mcause=0x8000_0007, MIE=0, MPIE=1.
//  3. i_meip, i_msip and i_lirq[2] high together, all enabled -> mcause=0x8000_0012.
//     After mret and lirq[2] drop -> next trap mcause=0x8000_000B.
//  4. ecall trap -> mcause=0x0000_000B. Store misaligned -> 0x0000_0006. ebreak -> 0x0000_0003.
//  5. CSRRS mcause imm=0x1F, then CSRRC 0x05 -> read 0x0000_001A. Writes to mip -> mip unchanged.
//  6. i_mtip held high across 3 instructions -> o_new_irq high for exactly 1 instruction.
//     i_rst_n pulsed mid-shift -> all outputs 0 within that clock.

Source files
------------

// File: rtl/serv_csr_pkg.sv
// Shared encodings for the bit-serial machine-mode CSR unit: CSR operand
// sources, local bit positions inside mstatus/mie/mip, and trap cause codes.
package serv_csr_pkg;

    // How the value written back to a CSR is formed from csr_out and d
    typedef enum logic [1:0] {
        CSR_SOURCE_CSR = 2'b00,
        CSR_SOURCE_EXT = 2'b01,
        CSR_SOURCE_SET = 2'b10,
        CSR_SOURCE_CLR = 2'b11
    } csr_source_e;

    // Bit positions held locally in this unit (all others live in the RF)
    localparam logic [4:0] MSTATUS_MIE_BIT  = 5'd3;
    localparam logic [4:0] MSTATUS_MPIE_BIT = 5'd7;
    localparam logic [4:0] IRQ_MSI_BIT      = 5'd3;
    localparam logic [4:0] IRQ_MTI_BIT      = 5'd7;
    localparam logic [4:0] IRQ_MEI_BIT      = 5'd11;
    localparam logic [4:0] IRQ_LOCAL_BASE   = 5'd16;
    localparam logic [4:0] MCAUSE_INT_BIT   = 5'd31;
    localparam logic [4:0] MCAUSE_CODE_BITS = 5'd5;

    // Interrupt cause codes equal their mie/mip bit index
    localparam logic [4:0] IRQ_CODE_MSI = 5'd3;
    localparam logic [4:0] IRQ_CODE_MTI = 5'd7;
    localparam logic [4:0] IRQ_CODE_MEI = 5'd11;

    // Synchronous exception cause codes
    localparam logic [4:0] EXC_CODE_JUMP  = 5'd0;
    localparam logic [4:0] EXC_CODE_BREAK = 5'd3;
    localparam logic [4:0] EXC_CODE_LOAD  = 5'd4;
    localparam logic [4:0] EXC_CODE_STORE = 5'd6;
    localparam logic [4:0] EXC_CODE_ECALL = 5'd11;

    // Cause code of a synchronous exception from the decoder's class flags
    function automatic logic [4:0] exc_code(input logic e_op,
                                            input logic ebreak,
                                            input logic mem_op,
                                            input logic mem_cmd);
        logic [4:0] code;
        if (e_op) begin
            code = ebreak ? EXC_CODE_BREAK : EXC_CODE_ECALL;
        end else if (mem_op) begin
            code = mem_cmd ? EXC_CODE_STORE : EXC_CODE_LOAD;
        end else begin
            code = EXC_CODE_JUMP;
        end
        return code;
    endfunction

endpackage

// File: rtl/serv_irq_prio.sv
// Interrupt front end: optional 2-flop synchronisers on every request line,
// pending = mip & mie, and a fixed-priority encoder producing the 5-bit cause.
// Priority, highest first: lirq[NUM_LOCAL-1]..lirq[0], MEI, MSI, MTI.
module serv_irq_prio
    import serv_csr_pkg::*;
#(
    parameter int NUM_LOCAL = 4,
    parameter bit SYNC      = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_msip,
    input  logic                 i_mtip,
    input  logic                 i_meip,
    input  logic [NUM_LOCAL-1:0] i_lirq,
    input  logic                 i_msie,
    input  logic                 i_mtie,
    input  logic                 i_meie,
    input  logic [NUM_LOCAL-1:0] i_lie,
    output logic                 o_mip_msi,
    output logic                 o_mip_mti,
    output logic                 o_mip_mei,
    output logic [NUM_LOCAL-1:0] o_mip_local,
    output logic                 o_pending,
    output logic [4:0]           o_irq_id
);

    localparam int W = NUM_LOCAL + 3;

    logic [W-1:0]         raw_s;
    logic [W-1:0]         lvl_s;
    logic                 pend_msi_s;
    logic                 pend_mti_s;
    logic                 pend_mei_s;
    logic [NUM_LOCAL-1:0] pend_local_s;
    logic [4:0]           id_s;

    assign raw_s = {i_lirq, i_meip, i_mtip, i_msip};

    generate
        if (SYNC) begin : g_sync
            logic [W-1:0] meta_q;
            logic [W-1:0] sync_q;

            // Two-flop synchroniser for the asynchronous request levels
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    meta_q <= '0;
                    sync_q <= '0;
                end else begin
                    meta_q <= raw_s;
                    sync_q <= meta_q;
                end
            end

            assign lvl_s = sync_q;
        end else begin : g_nosync
            assign lvl_s = raw_s;
        end
    endgenerate

    assign o_mip_msi   = lvl_s[0];
    assign o_mip_mti   = lvl_s[1];
    assign o_mip_mei   = lvl_s[2];
    assign o_mip_local = lvl_s[W-1:3];

    // Pending mask and priority encode; later assignments override earlier ones
    always_comb begin
        pend_msi_s   = lvl_s[0] & i_msie;
        pend_mti_s   = lvl_s[1] & i_mtie;
        pend_mei_s   = lvl_s[2] & i_meie;
        pend_local_s = lvl_s[W-1:3] & i_lie;
        id_s         = 5'd0;
        id_s         = pend_mti_s ? IRQ_CODE_MTI : id_s;
        id_s         = pend_msi_s ? IRQ_CODE_MSI : id_s;
        id_s         = pend_mei_s ? IRQ_CODE_MEI : id_s;
        for (int k = 0; k < NUM_LOCAL; k++) begin
            id_s = pend_local_s[k] ? (IRQ_LOCAL_BASE + 5'(k)) : id_s;
        end
    end

    assign o_pending = pend_msi_s | pend_mti_s | pend_mei_s | (|pend_local_s);
    assign o_irq_id  = id_s;

endmodule

// File: rtl/serv_csr_irq.sv
// Bit-serial machine-mode CSR unit with multi-source interrupts. Operands move
// one bit per clock, LSB first; only the CSR bits with hardware meaning live
// here (mstatus.MIE/MPIE, mie enables, mcause code and interrupt flag), the
// rest are carried by the register file and OR-ed in through i_rf_csr_out.
module serv_csr_irq
    import serv_csr_pkg::*;
#(
    parameter int NUM_LOCAL = 4,
    parameter bit SYNC      = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_init,
    input  logic                 i_en,
    input  logic [4:0]           i_cnt,
    input  logic                 i_cnt_done,
    input  logic                 i_trap,
    input  logic                 i_mret,
    input  logic                 i_e_op,
    input  logic                 i_ebreak,
    input  logic                 i_mem_op,
    input  logic                 i_mem_cmd,
    input  logic                 i_mstatus_en,
    input  logic                 i_mie_en,
    input  logic                 i_mip_en,
    input  logic                 i_mcause_en,
    input  logic [1:0]           i_csr_source,
    input  logic                 i_csr_d_sel,
    input  logic                 i_csr_imm,
    input  logic                 i_rs1,
    input  logic                 i_rf_csr_out,
    input  logic                 i_msip,
    input  logic                 i_mtip,
    input  logic                 i_meip,
    input  logic [NUM_LOCAL-1:0] i_lirq,
    output logic                 o_csr_in,
    output logic                 o_q,
    output logic                 o_new_irq,
    output logic                 o_irq_pending
);

    // Architectural state
    logic                 mstatus_mie_q;
    logic                 mstatus_mpie_q;
    logic                 msie_q;
    logic                 mtie_q;
    logic                 meie_q;
    logic [NUM_LOCAL-1:0] lie_q;
    logic [4:0]           code_q;
    logic [4:0]           code_d;
    logic                 cause_int_q;
    logic                 cause_int_d;

    // Interrupt sequencing state
    logic [4:0]           irq_id_q;
    logic                 new_irq_q;
    logic                 irq_taken_q;
    logic                 irq_pending_q;

    // Combinational datapath
    logic                 mip_msi_s;
    logic                 mip_mti_s;
    logic                 mip_mei_s;
    logic [NUM_LOCAL-1:0] mip_local_s;
    logic                 pending_s;
    logic [4:0]           prio_id_s;
    logic                 take_s;
    logic                 mie_bit_s;
    logic                 mip_bit_s;
    logic                 local_bit_s;
    logic                 csr_out_s;
    logic                 csr_d_s;
    logic                 csr_in_s;
    logic                 trap_done_s;
    logic                 mret_done_s;
    logic                 mie_wr_s;

    serv_irq_prio #(
        .NUM_LOCAL (NUM_LOCAL),
        .SYNC      (SYNC)
    ) u_prio (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_msip      (i_msip),
        .i_mtip      (i_mtip),
        .i_meip      (i_meip),
        .i_lirq      (i_lirq),
        .i_msie      (msie_q),
        .i_mtie      (mtie_q),
        .i_meie      (meie_q),
        .i_lie       (lie_q),
        .o_mip_msi   (mip_msi_s),
        .o_mip_mti   (mip_mti_s),
        .o_mip_mei   (mip_mei_s),
        .o_mip_local (mip_local_s),
        .o_pending   (pending_s),
        .o_irq_id    (prio_id_s)
    );

    assign trap_done_s = i_trap & i_cnt_done;
    assign mret_done_s = i_mret & i_cnt_done;
    assign mie_wr_s    = i_en & i_mie_en;
    assign take_s      = mstatus_mie_q & pending_s;

    // mie/mip bit at the current serial index (shared bit layout)
    always_comb begin
        mie_bit_s = 1'b0;
        mip_bit_s = 1'b0;
        case (i_cnt)
            IRQ_MSI_BIT: begin
                mie_bit_s = msie_q;
                mip_bit_s = mip_msi_s;
            end
            IRQ_MTI_BIT: begin
                mie_bit_s = mtie_q;
                mip_bit_s = mip_mti_s;
            end
            IRQ_MEI_BIT: begin
                mie_bit_s = meie_q;
                mip_bit_s = mip_mei_s;
            end
            default: begin
                for (int k = 0; k < NUM_LOCAL; k++) begin
                    mie_bit_s = mie_bit_s | ((i_cnt == (IRQ_LOCAL_BASE + 5'(k))) & lie_q[k]);
                    mip_bit_s = mip_bit_s | ((i_cnt == (IRQ_LOCAL_BASE + 5'(k))) & mip_local_s[k]);
                end
            end
        endcase
    end

    // Locally held bit of the selected CSR; zero outside a valid serial bit
    always_comb begin
        local_bit_s = 1'b0;
        if (!i_en) begin
            local_bit_s = 1'b0;
        end else if (i_mstatus_en) begin
            local_bit_s = (i_cnt == MSTATUS_MIE_BIT)  ? mstatus_mie_q  :
                          (i_cnt == MSTATUS_MPIE_BIT) ? mstatus_mpie_q : 1'b0;
        end else if (i_mie_en) begin
            local_bit_s = mie_bit_s;
        end else if (i_mip_en) begin
            local_bit_s = mip_bit_s;
        end else if (i_mcause_en) begin
            local_bit_s = (i_cnt < MCAUSE_CODE_BITS) ? code_q[0]   :
                          (i_cnt == MCAUSE_INT_BIT)  ? cause_int_q : 1'b0;
        end else begin
            local_bit_s = 1'b0;
        end
    end

    assign csr_out_s = i_rf_csr_out | local_bit_s;
    assign csr_d_s   = i_csr_d_sel ? i_csr_imm : i_rs1;

    // Write-back value for CSRRW/CSRRS/CSRRC and plain reads
    always_comb begin
        csr_in_s = csr_out_s;
        case (csr_source_e'(i_csr_source))
            CSR_SOURCE_EXT: csr_in_s = csr_d_s;
            CSR_SOURCE_SET: csr_in_s = csr_out_s | csr_d_s;
            CSR_SOURCE_CLR: csr_in_s = csr_out_s & ~csr_d_s;
            CSR_SOURCE_CSR: csr_in_s = csr_out_s;
            default:        csr_in_s = csr_out_s;
        endcase
    end

    assign o_csr_in = csr_in_s;
    assign o_q      = csr_out_s;

    // mstatus MIE/MPIE: trap entry beats mret, mret beats CSR writes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
        end else if (trap_done_s) begin
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
        end else if (mret_done_s) begin
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
        end else if (i_en && i_mstatus_en && !i_mret) begin
            if (i_cnt == MSTATUS_MIE_BIT) begin
                mstatus_mie_q <= csr_in_s;
            end else if (i_cnt == MSTATUS_MPIE_BIT) begin
                mstatus_mpie_q <= csr_in_s;
            end else begin
                mstatus_mie_q <= mstatus_mie_q;
            end
        end else begin
            mstatus_mie_q <= mstatus_mie_q;
        end
    end

    // mie enable bits, each loaded when the serial index reaches it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            msie_q <= 1'b0;
            mtie_q <= 1'b0;
            meie_q <= 1'b0;
            lie_q  <= '0;
        end else begin
            if (mie_wr_s && (i_cnt == IRQ_MSI_BIT)) msie_q <= csr_in_s;
            if (mie_wr_s && (i_cnt == IRQ_MTI_BIT)) mtie_q <= csr_in_s;
            if (mie_wr_s && (i_cnt == IRQ_MEI_BIT)) meie_q <= csr_in_s;
            for (int k = 0; k < NUM_LOCAL; k++) begin
                if (mie_wr_s && (i_cnt == (IRQ_LOCAL_BASE + 5'(k)))) lie_q[k] <= csr_in_s;
            end
        end
    end

    // mcause next state: trap load, else rotate code through bits 0..4
    always_comb begin
        code_d      = code_q;
        cause_int_d = cause_int_q;
        if (trap_done_s) begin
            cause_int_d = new_irq_q;
            code_d      = new_irq_q ? irq_id_q : exc_code(i_e_op, i_ebreak, i_mem_op, i_mem_cmd);
        end else if (i_en && i_mcause_en) begin
            code_d      = (i_cnt < MCAUSE_CODE_BITS) ? {csr_in_s, code_q[4:1]} : code_q;
            cause_int_d = i_cnt_done ? csr_in_s : cause_int_q;
        end else begin
            code_d      = code_q;
            cause_int_d = cause_int_q;
        end
    end

    // mcause registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            code_q      <= 5'd0;
            cause_int_q <= 1'b0;
        end else begin
            code_q      <= code_d;
            cause_int_q <= cause_int_d;
        end
    end

    // Interrupt take/re-arm: one new_irq per rising edge of take
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            irq_pending_q <= 1'b0;
            irq_id_q      <= 5'd0;
            new_irq_q     <= 1'b0;
            irq_taken_q   <= 1'b0;
        end else begin
            irq_pending_q <= pending_s;
            if (i_cnt_done && !i_init) begin
                irq_id_q    <= prio_id_s;
                new_irq_q   <= take_s & ~irq_taken_q;
                irq_taken_q <= take_s;
            end else begin
                irq_id_q    <= irq_id_q;
                new_irq_q   <= new_irq_q;
                irq_taken_q <= irq_taken_q;
            end
        end
    end

    assign o_new_irq     = new_irq_q;
    assign o_irq_pending = irq_pending_q;

endmodule
